// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller feeding the decode-stage pipeline register.
// Issues one single-beat read per accepted fetch and waits a variable time for the reply.
// It then presents the instruction on a valid/ready bus until decode takes it.
// Misaligned PCs, bus errors and response timeouts all deliver an ebreak with fetch_err set.
module ifu_fetch_ctrl #(
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic [31:0] pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        valid,
    input  logic        ready,
    output logic        fetch_err,
    output logic        busy
);

    // Counter wide enough to hold TIMEOUT; keep at least one bit when the timeout is disabled.
    localparam int unsigned CW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST   = CW'(TO_LAST_INT);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   inst_q, inst_d;
    logic [31:0]   inst_pc_q, inst_pc_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // Outputs come straight from registers or the decoded state; no input reaches an output.
    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = addr_q;
    assign valid         = (state_q == HOLD);
    assign busy          = (state_q != IDLE);
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign fetch_err     = err_q;

    // Next-state logic: handshakes, response capture, timeout and fault substitution.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                accept = 1'b1;
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    // A response always beats a timeout landing in the same cycle.
                    state_d   = HOLD;
                    inst_pc_d = addr_q;
                    if (mem_resp_err) begin
                        inst_d = EBREAK_INST;
                        err_d  = 1'b1;
                    end else begin
                        inst_d = mem_resp_data;
                        err_d  = 1'b0;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d   = HOLD;
                    inst_pc_d = addr_q;
                    inst_d    = EBREAK_INST;
                    err_d     = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (ready) begin
                    state_d = IDLE;
                    accept  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new fetch may start from IDLE or on the cycle decode takes the held instruction.
        if (accept && fetch_start) begin
            addr_d = pc;
            if (pc[1:0] == 2'b00) begin
                state_d = REQ;
            end else begin
                // Misaligned: never touch memory, hand decode an ebreak directly.
                state_d   = HOLD;
                inst_d    = EBREAK_INST;
                inst_pc_d = pc;
                err_d     = 1'b1;
            end
        end
    end

    // State and datapath registers; reset aborts any fetch in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: directed scenarios followed by randomized fetches.
// Expected timing and data come from a per-transaction model of latency arithmetic.
module tb_ifu_fetch_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_start = 1'b0;
    logic [31:0] pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        mem_resp_err = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        valid;
    logic        ready = 1'b0;
    logic        fetch_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ifu_fetch_ctrl #(
        .TIMEOUT    (TIMEOUT),
        .EBREAK_INST(EBREAK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_start   (fetch_start),
        .pc            (pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .mem_resp_err  (mem_resp_err),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .valid         (valid),
        .ready         (ready),
        .fetch_err     (fetch_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Compare one observed value against the model's expectation.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%08h expected=%08h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 4) != 0) r[1:0] = 2'b00;
        else                           r[1:0] = 2'($urandom_range(1, 3));
        return r;
    endfunction

    // One fetch transaction. rd = cycles mem_req_ready stays low, wd = WAIT cycles before the
    // response (wd >= TIMEOUT means the reply comes too late), hd = cycles decode stalls.
    // started=1: fetch_start was already accepted in the previous cycle (back-to-back).
    // chain=1: assert fetch_start with npc on the cycle decode accepts this instruction.
    task automatic run_fetch(input logic [31:0] fpc, input int rd, input int wd,
                             input bit rerr, input logic [31:0] rdata, input int hd,
                             input bit started, input bit chain, input logic [31:0] npc);
        bit          aligned;
        bit          exp_mreq;
        bit          in_hold;
        int          wd_eff, hs, kready, kend, resp_k;
        logic [31:0] exp_inst;
        logic        exp_err;

        aligned = (fpc[1:0] == 2'b00);
        wd_eff  = (wd < int'(TIMEOUT)) ? wd : int'(TIMEOUT) - 1;
        hs      = aligned ? 3 + rd + wd_eff : 1;
        kready  = hs + hd;
        kend    = chain ? kready : kready + 1;
        resp_k  = 2 + rd + wd;
        if (aligned && (wd < int'(TIMEOUT)) && !rerr) begin
            exp_inst = rdata;
            exp_err  = 1'b0;
        end else begin
            exp_inst = EBREAK;
            exp_err  = 1'b1;
        end

        if (!started) begin
            fetch_start    = 1'b1;
            pc             = fpc;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            ready          = 1'b0;
            chk("start_busy", {31'b0, busy}, 32'd0);
            chk("start_valid", {31'b0, valid}, 32'd0);
            tick();
        end

        for (int k = 1; k <= kend; k++) begin
            if (k < kready) begin
                fetch_start = 1'($urandom_range(0, 1));
                pc          = $urandom;
            end else if (k == kready) begin
                fetch_start = chain;
                pc          = npc;
            end else begin
                fetch_start = 1'b0;
                pc          = $urandom;
            end
            ready = (k < hs) ? 1'($urandom_range(0, 1)) : (k == kready);
            if (aligned && k < 1 + rd)       mem_req_ready = 1'b0;
            else if (aligned && k == 1 + rd) mem_req_ready = 1'b1;
            else                             mem_req_ready = 1'($urandom_range(0, 1));
            mem_resp_data = $urandom;
            mem_resp_err  = 1'($urandom_range(0, 1));
            if (aligned && k == resp_k) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = rdata;
                mem_resp_err   = rerr;
            end else if (aligned && k >= 2 + rd && k < resp_k) begin
                mem_resp_valid = 1'b0;
            end else begin
                mem_resp_valid = 1'($urandom_range(0, 1));
            end

            exp_mreq = aligned && (k <= 1 + rd);
            in_hold  = (k >= hs) && (k <= kready);
            chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, exp_mreq});
            if (exp_mreq) chk("mem_addr", mem_addr, fpc);
            chk("valid", {31'b0, valid}, {31'b0, in_hold});
            chk("busy", {31'b0, busy}, {31'b0, (k <= kready)});
            if (in_hold) begin
                chk("inst", inst, exp_inst);
                chk("inst_pc", inst_pc, fpc);
                chk("fetch_err", {31'b0, fetch_err}, {31'b0, exp_err});
            end
            tick();
        end
        fetch_start    = 1'b0;
        mem_resp_valid = 1'b0;
        ready          = 1'b0;
        $display("TXN pc=%08h rd=%0d wd=%0d err=%0d hd=%0d chain=%0d exp_inst=%08h exp_ferr=%0d",
                 fpc, rd, wd, rerr, hd, chain, exp_inst, exp_err);
    endtask

    // Reset asserted between clock edges while WAIT is pending, then a stray response.
    task automatic reset_mid_wait();
        fetch_start    = 1'b1;
        pc             = 32'h8000_0040;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        ready          = 1'b0;
        tick();
        fetch_start   = 1'b0;
        mem_req_ready = 1'b1;
        chk("rst_pre_mreq", {31'b0, mem_req_valid}, 32'd1);
        tick();
        mem_req_ready = 1'b0;
        chk("rst_pre_busy", {31'b0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'b0, valid}, 32'd0);
        chk("rst_async_busy", {31'b0, busy}, 32'd0);
        chk("rst_async_mreq", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_async_addr", mem_addr, 32'd0);
        tick();
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0013;
        mem_resp_err   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_stray_valid", {31'b0, valid}, 32'd0);
            chk("rst_stray_busy", {31'b0, busy}, 32'd0);
        end
        mem_resp_valid = 1'b0;
        $display("TXN reset during WAIT, stray response ignored");
    endtask

    // Main sequence: reset state, directed scenarios, randomized fetches, summary.
    initial begin
        logic [31:0] cur_pc, npc;
        bit          started, chain;

        #2;
        rst = 1'b1;
        #1;
        chk("reset_valid", {31'b0, valid}, 32'd0);
        chk("reset_mreq", {31'b0, mem_req_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_ferr", {31'b0, fetch_err}, 32'd0);
        chk("reset_inst", inst, 32'd0);
        chk("reset_inst_pc", inst_pc, 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        run_fetch(32'h8000_0000, 0, 0, 1'b0, 32'h0000_0413, 0, 1'b0, 1'b0, 32'h0);
        run_fetch(32'h8000_0010, 2, 3, 1'b0, 32'h1234_5678, 3, 1'b0, 1'b0, 32'h0);
        run_fetch(32'h8000_0002, 0, 0, 1'b0, 32'h0,         1, 1'b0, 1'b0, 32'h0);
        run_fetch(32'h8000_0020, 0, 1, 1'b1, 32'hdead_beef, 0, 1'b0, 1'b0, 32'h0);
        run_fetch(32'h8000_0024, 1, 6, 1'b0, 32'hcafe_f00d, 1, 1'b0, 1'b0, 32'h0);
        run_fetch(32'h8000_0028, 0, 3, 1'b0, 32'h0051_0513, 0, 1'b0, 1'b0, 32'h0);
        run_fetch(32'h8000_0000, 0, 0, 1'b0, 32'h0000_0413, 1, 1'b0, 1'b1, 32'h8000_0004);
        run_fetch(32'h8000_0004, 1, 2, 1'b0, 32'h0020_0093, 0, 1'b1, 1'b0, 32'h0);
        reset_mid_wait();

        started = 1'b0;
        cur_pc  = rand_pc();
        for (int n = 0; n < 60; n++) begin
            chain = ($urandom_range(0, 3) == 0) && (n < 59);
            npc   = rand_pc();
            run_fetch(cur_pc, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                      ($urandom_range(0, 4) == 0), $urandom, int'($urandom_range(0, 3)),
                      started, chain, npc);
            started = chain;
            cur_pc  = chain ? npc : rand_pc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so a broken design can never stall the run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
